fpu_arbiter: RTL and testbench

Shares one FpuManager instance between N requesters (CPU core thread contexts, DMA/vector helpers). It uses round-robin arbitration and issues each operation with a one-cycle `q` pulse. It then waits for the manager's `dn` pulse and routes the result back to the granted requester. A per-operation timeout guarantees forward progress if `dn` never arrives. The block sits between the requesters and FpuManager and is the only driver of FpuManager's `op`/`a`/`b`/`q`.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_arbiter_rr_pick.sv | 30 +++
 rtl/fpu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fpu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request arbiter.
// State encoding, FPU op codes and default timeout.
package fpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } arb_state_t;

  localparam logic [2:0] FPU_ADD = 3'd0;
  localparam logic [2:0] FPU_SUB = 3'd1;
  localparam logic [2:0] FPU_MUL = 3'd2;
  localparam logic [2:0] FPU_DIV = 3'd3;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or
// above ptr, wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] w
);

  int w_j;

  // Scan farthest offset first so the nearest hit is written last.
  always_comb begin
    any = 1'b0;
    w   = '0;
    w_j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (req[w_j]) begin
        any = 1'b1;
        w   = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FpuManager between N requesters,
// with a per-operation timeout so a lost dn cannot hang the port.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int N       = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_oe,
  input  logic [N-1:0]    req,
  input  logic [3*N-1:0]  req_op,
  input  logic [DW*N-1:0] req_a,
  input  logic [DW*N-1:0] req_b,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    res_dn,
  output logic [DW-1:0]   res_out,
  output logic            res_err,
  output logic            fpu_q,
  output logic [2:0]      fpu_op,
  output logic [DW-1:0]   fpu_a,
  output logic [DW-1:0]   fpu_b,
  input  logic [DW-1:0]   fpu_out,
  input  logic            fpu_dn,
  output logic            busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_t       r_state;
  arb_state_t       w_nstate;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_w;
  logic [2:0]       r_op;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [DW-1:0]    r_res;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_ptr_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_to;
  logic [N-1:0]     w_oh;
  logic [2:0]       w_op [N];
  logic [DW-1:0]    w_a  [N];
  logic [DW-1:0]    w_b  [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_op[g] = req_op[3*g +: 3];
    assign w_a[g]  = req_a[DW*g +: DW];
    assign w_b[g]  = req_b[DW*g +: DW];
  end

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .w   (w_win)
  );

  assign w_ptr_nx = (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_to     = (w_cnt_nx == CNT_W'(TIMEOUT));
  assign w_oh     = {{(N-1){1'b0}}, 1'b1} << r_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (clk_oe) begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any) w_nstate = S_ISSUE;
      S_ISSUE:  w_nstate = S_WAIT;
      S_WAIT:   if (fpu_dn || w_to) w_nstate = S_RETURN;
      S_RETURN: w_nstate = S_IDLE;
      default:  w_nstate = S_IDLE;
    endcase
  end

  // dn is tested before the timeout so a same-cycle finish wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
      r_w   <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (clk_oe) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_w   <= w_win;
            r_op  <= w_op[w_win];
            r_a   <= w_a[w_win];
            r_b   <= w_b[w_win];
            r_ptr <= w_ptr_nx;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= w_cnt_nx;
          if (fpu_dn) begin
            r_res <= fpu_out;
            r_err <= 1'b0;
          end else if (w_to) begin
            r_res <= '0;
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt     = '0;
    res_dn  = '0;
    res_out = '0;
    res_err = 1'b0;
    fpu_q   = 1'b0;
    fpu_op  = '0;
    fpu_a   = '0;
    fpu_b   = '0;
    busy    = (r_state != S_IDLE);
    unique case (r_state)
      S_ISSUE: begin
        gnt    = w_oh;
        fpu_q  = 1'b1;
        fpu_op = r_op;
        fpu_a  = r_a;
        fpu_b  = r_b;
      end
      S_WAIT: begin
        fpu_op = r_op;
        fpu_a  = r_a;
        fpu_b  = r_b;
      end
      S_RETURN: begin
        res_dn  = w_oh;
        res_out = r_res;
        res_err = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a small FpuManager model.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clk_oe = 1'b1;
  logic [N-1:0]    req = '0;
  logic [3*N-1:0]  req_op = '0;
  logic [DW*N-1:0] req_a = '0;
  logic [DW*N-1:0] req_b = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    res_dn;
  logic [DW-1:0]   res_out;
  logic            res_err;
  logic            fpu_q;
  logic [2:0]      fpu_op;
  logic [DW-1:0]   fpu_a;
  logic [DW-1:0]   fpu_b;
  logic [DW-1:0]   fpu_out = '0;
  logic            fpu_dn;
  logic            busy;
  logic            m_dn = 1'b0;
  logic            s_dn = 1'b0;

  assign fpu_dn = m_dn | s_dn;

  fpu_arbiter #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe),
    .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .res_dn(res_dn), .res_out(res_out),
    .res_err(res_err), .fpu_q(fpu_q), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_out(fpu_out),
    .fpu_dn(fpu_dn), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    int            d;
  } iss_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] res;
    logic          err;
    int            lat;
  } ret_t;

  iss_t iq[$];
  ret_t rq[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int unexp = 0;
  int gcyc [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(string nm);
    tests++;
    fails++;
    $display("FAIL %s: cycle bound expired (cycle %0d)", nm, cyc);
  endtask

  // Monitor plus FpuManager model: dn is raised in WAIT cycle d.
  logic [N-1:0]  pg = '0;
  logic [N-1:0]  pd = '0;
  bit            bchk = 0;
  bit            m_arm = 0;
  int            m_d = 0;
  int            m_cnt = 0;
  logic [DW-1:0] m_res = '0;
  iss_t          ie;
  ret_t          re;

  always @(negedge clk) begin
    if (bchk) begin
      chk("busy_after_ret", 64'(busy), 64'(0));
      bchk = 0;
    end
    if (res_dn == '0)
      chk("res_out_idle", 64'(res_out), 64'(0));
    if (gnt != '0 && pg == '0) begin
      if (iq.size() == 0) begin
        chk("unexp_gnt", 64'(gnt), 64'(0));
      end else begin
        ie = iq.pop_front();
        chk("gnt_idx", 64'(gnt), 64'(1) << ie.idx);
        chk("fpu_q", 64'(fpu_q), 64'(1));
        chk("fpu_op", 64'(fpu_op), 64'(ie.op));
        chk("fpu_a", 64'(fpu_a), 64'(ie.a));
        chk("fpu_b", 64'(fpu_b), 64'(ie.b));
        gcyc[ie.idx] = cyc;
        m_d   = ie.d;
        m_res = ie.res;
      end
    end
    if (res_dn != '0 && pd == '0) begin
      if (rq.size() == 0) begin
        unexp++;
        chk("unexp_res_dn", 64'(res_dn), 64'(0));
      end else begin
        re = rq.pop_front();
        chk("res_dn_idx", 64'(res_dn), 64'(1) << re.idx);
        chk("res_out", 64'(res_out), 64'(re.res));
        chk("res_err", 64'(res_err), 64'(re.err));
        chk("latency", 64'(cyc - gcyc[re.idx]), 64'(re.lat));
        bchk = 1;
      end
    end
    pg = gnt;
    pd = res_dn;
    m_dn = 1'b0;
    if (fpu_q) begin
      m_cnt = 0;
      m_arm = (m_d != 0);
    end else if (m_arm) begin
      m_cnt++;
      if (m_cnt == m_d) begin
        m_dn    = 1'b1;
        fpu_out = m_res;
        m_arm   = 0;
      end
    end
  end

  task automatic setop(int i, logic [2:0] op, logic [DW-1:0] a,
                       logic [DW-1:0] b);
    req_op[3*i +: 3] = op;
    req_a[DW*i +: DW] = a;
    req_b[DW*i +: DW] = b;
  endtask

  // d==0 means the model never answers, so the timeout fires.
  task automatic push(int i, logic [2:0] op, logic [DW-1:0] a,
                      logic [DW-1:0] b, logic [DW-1:0] res, int d,
                      bit ret, int ext);
    iss_t e;
    ret_t r;
    e.idx = i; e.op = op; e.a = a; e.b = b; e.res = res; e.d = d;
    iq.push_back(e);
    if (ret) begin
      r.idx = i;
      r.res = (d == 0) ? '0 : res;
      r.err = (d == 0);
      r.lat = 1 + ext + ((d == 0) ? TO : d);
      rq.push_back(r);
    end
  endtask

  // Drop req on grant, re-raise once on completion for bits in rr.
  task automatic run(logic [N-1:0] rr, int maxc, string nm);
    int n = 0;
    logic [N-1:0] again = rr;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        if (res_dn[i] && again[i]) begin
          req[i]   = 1'b1;
          again[i] = 1'b0;
        end
      end
      if (req == '0 && again == '0 && iq.size() == 0 &&
          rq.size() == 0 && !busy && !bchk)
        break;
    end
    if (n >= maxc) bound_fail(nm);
  endtask

  task automatic wait_gnt(int i, int maxc, string nm);
    int n = 0;
    while (!gnt[i] && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) bound_fail(nm);
    req[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_fpu_q", 64'(fpu_q), 64'(0));
    chk("rst_res_dn", 64'(res_dn), 64'(0));
    rst = 1'b1;

    // Single request: 1.0 + 2.0 = 3.0, dn in WAIT cycle 6
    setop(0, FPU_ADD, 32'h3F80_0000, 32'h4000_0000);
    push(0, FPU_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
         6, 1, 0);
    req[0] = 1'b1;
    run('0, 100, "single");

    // Reset in IDLE returns ptr to 0, then fairness 0,1,2,3,0,1,2,3
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    setop(1, FPU_SUB, 32'h4040_0000, 32'h3F80_0000);
    setop(2, FPU_MUL, 32'h4000_0000, 32'h4040_0000);
    setop(3, FPU_DIV, 32'h40C0_0000, 32'h4000_0000);
    for (int k = 0; k < 2; k++) begin
      push(0, FPU_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
           3, 1, 0);
      push(1, FPU_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000,
           3, 1, 0);
      push(2, FPU_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000,
           3, 1, 0);
      push(3, FPU_DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000,
           3, 1, 0);
    end
    req = '1;
    run('1, 400, "fairness");

    // Timeout: ptr=0 but only requester 2 asks
    push(2, FPU_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000,
         0, 1, 0);
    req[2] = 1'b1;
    run('0, 100, "timeout");

    // dn coincident with the timeout count: 2.0 + 3.0 = 5.0
    setop(1, FPU_ADD, 32'h4000_0000, 32'h4040_0000);
    push(1, FPU_ADD, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000,
         TO, 1, 0);
    req[1] = 1'b1;
    run('0, 100, "coincide");

    // Stray dn in IDLE
    s_dn = 1'b1;
    @(negedge clk);
    s_dn = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_unexp", 64'(unexp), 64'(0));
    chk("stray_busy", 64'(busy), 64'(0));

    // Reset mid-WAIT on requester 1 (ptr becomes 2 before reset)
    setop(1, FPU_DIV, 32'h40C0_0000, 32'h4000_0000);
    push(1, FPU_DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000,
         0, 0, 0);
    req[1] = 1'b1;
    wait_gnt(1, 20, "rst_mid_gnt");
    repeat (3) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    chk("mid_fpu_op", 64'(fpu_op), 64'(FPU_DIV));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_gnt", 64'(gnt), 64'(0));
    chk("mr_fpu_q", 64'(fpu_q), 64'(0));
    chk("mr_fpu_op", 64'(fpu_op), 64'(0));
    chk("mr_fpu_a", 64'(fpu_a), 64'(0));
    chk("mr_fpu_b", 64'(fpu_b), 64'(0));
    chk("mr_res_err", 64'(res_err), 64'(0));
    s_dn = 1'b1;
    @(negedge clk);
    s_dn = 1'b0;
    repeat (TO + 4) @(negedge clk);
    chk("mr_no_res_dn", 64'(unexp), 64'(0));

    // ptr probe: 0 and 2 together; ptr=0 picks 0 first
    setop(0, FPU_ADD, 32'h3F80_0000, 32'h3F80_0000);
    setop(2, FPU_MUL, 32'h4040_0000, 32'h4040_0000);
    push(0, FPU_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000,
         2, 1, 0);
    push(2, FPU_MUL, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000,
         2, 1, 0);
    req[0] = 1'b1;
    req[2] = 1'b1;
    run('0, 100, "ptr_probe");

    // Clock-enable hold in ISSUE: 3.0 - 1.0 = 2.0
    setop(0, FPU_SUB, 32'h4040_0000, 32'h3F80_0000);
    push(0, FPU_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000,
         2, 1, 3);
    req[0] = 1'b1;
    wait_gnt(0, 20, "oe_gnt");
    clk_oe = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("oe_gnt_hold", 64'(gnt), 64'(1));
      chk("oe_q_hold", 64'(fpu_q), 64'(1));
    end
    clk_oe = 1'b1;
    @(negedge clk);
    chk("oe_gnt_drop", 64'(gnt), 64'(0));
    chk("oe_q_drop", 64'(fpu_q), 64'(0));
    chk("oe_busy", 64'(busy), 64'(1));
    run('0, 100, "oe_finish");

    chk("iq_empty", 64'(iq.size()), 64'(0));
    chk("rq_empty", 64'(rq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
